// File: rtl/hazard_ctrl_if.sv
// Decode-stage interlock bundle between id_stage and hazard_ctrl.
// Master is the ID/EX/LSU side, slave is the controller.
interface hazard_ctrl_if;
  logic        id_valid;
  logic        id_rs1_r_ena;
  logic [4:0]  id_rs1_r_addr;
  logic        id_rs2_r_ena;
  logic [4:0]  id_rs2_r_addr;
  logic        id_rd_w_ena;
  logic [4:0]  id_rd_w_addr;
  logic        id_mem_to_reg;
  logic        id_fence;
  logic        ex_redirect;
  logic        ld_done;
  logic [4:0]  ld_done_addr;
  logic        mem_busy;
  logic        id_stall;
  logic        id_fire;
  logic        flush_if;
  logic        flush_id;
  logic [31:0] ld_pending;
  logic [3:0]  ld_outstanding;
  logic        fence_busy;

  modport master (
    output id_valid, id_rs1_r_ena, id_rs1_r_addr,
    output id_rs2_r_ena, id_rs2_r_addr,
    output id_rd_w_ena, id_rd_w_addr,
    output id_mem_to_reg, id_fence, ex_redirect,
    output ld_done, ld_done_addr, mem_busy,
    input  id_stall, id_fire, flush_if, flush_id,
    input  ld_pending, ld_outstanding, fence_busy
  );

  modport slave (
    input  id_valid, id_rs1_r_ena, id_rs1_r_addr,
    input  id_rs2_r_ena, id_rs2_r_addr,
    input  id_rd_w_ena, id_rd_w_addr,
    input  id_mem_to_reg, id_fence, ex_redirect,
    input  ld_done, ld_done_addr, mem_busy,
    output id_stall, id_fire, flush_if, flush_id,
    output ld_pending, ld_outstanding, fence_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Decode-stage interlock: load scoreboard, fence drain
// and branch redirect bubble sequencing.
module hazard_ctrl #(
  parameter int MAX_LOADS        = 4,
  parameter int REDIRECT_BUBBLES = 1
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN,
    FENCE_WAIT,
    REDIRECT
  } state_t;

  localparam logic [3:0] MAXL = 4'(MAX_LOADS);
  localparam logic [2:0] NBUB = 3'(REDIRECT_BUBBLES);
  localparam state_t     RDST =
    (REDIRECT_BUBBLES > 0) ? REDIRECT : RUN;

  state_t      state, state_nx;
  logic [2:0]  bub, bub_nx;
  logic [31:0] pend, pend_nx;
  logic [3:0]  cnt, cnt_nx;

  logic raw, waw, full;
  logic stall, flush, fire;
  logic drained, done_ok, ld_inc;

  always_comb begin
    raw = (hz.id_rs1_r_ena
           & (hz.id_rs1_r_addr != 5'd0)
           & pend[hz.id_rs1_r_addr])
        | (hz.id_rs2_r_ena
           & (hz.id_rs2_r_addr != 5'd0)
           & pend[hz.id_rs2_r_addr]);
    waw = hz.id_rd_w_ena
        & (hz.id_rd_w_addr != 5'd0)
        & pend[hz.id_rd_w_addr];
    full = hz.id_mem_to_reg & (cnt == MAXL);
    drained = (cnt == 4'd0) & ~hz.mem_busy;
  end

  always_comb begin
    stall    = 1'b0;
    flush    = 1'b0;
    state_nx = state;
    bub_nx   = bub;
    unique case (state)
      FENCE_WAIT: begin
        if (hz.ex_redirect) begin
          flush    = 1'b1;
          state_nx = RDST;
          bub_nx   = NBUB;
        end else if (drained) begin
          state_nx = RUN;
        end else begin
          stall = 1'b1;
        end
      end
      REDIRECT: begin
        flush = 1'b1;
        if (hz.ex_redirect) begin
          bub_nx = NBUB;
        end else begin
          bub_nx = bub - 3'd1;
          if (bub == 3'd1) state_nx = RUN;
        end
      end
      default: begin
        if (hz.ex_redirect) begin
          flush    = 1'b1;
          state_nx = RDST;
          bub_nx   = NBUB;
        end else if (hz.id_valid & hz.id_fence
                     & ~drained) begin
          stall    = 1'b1;
          state_nx = FENCE_WAIT;
        end else begin
          stall = hz.id_valid & (raw | waw | full);
        end
      end
    endcase
  end

  assign fire = hz.id_valid & ~stall & ~flush;

  // A completion with nothing in flight is spurious and dropped.
  assign done_ok = hz.ld_done & (cnt != 4'd0);
  assign ld_inc  = fire & hz.id_mem_to_reg;

  always_comb begin
    pend_nx = pend;
    if (done_ok) pend_nx[hz.ld_done_addr] = 1'b0;
    if (ld_inc && hz.id_rd_w_addr != 5'd0)
      pend_nx[hz.id_rd_w_addr] = 1'b1;
    pend_nx[0] = 1'b0;
  end

  always_comb begin
    unique case ({ld_inc, done_ok})
      2'b10:   cnt_nx = cnt + 4'd1;
      2'b01:   cnt_nx = cnt - 4'd1;
      default: cnt_nx = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      bub   <= 3'd0;
      pend  <= 32'd0;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      bub   <= bub_nx;
      pend  <= pend_nx;
      cnt   <= cnt_nx;
    end
  end

  assign hz.id_stall       = stall;
  assign hz.id_fire        = fire;
  assign hz.flush_if       = flush;
  assign hz.flush_id       = flush;
  assign hz.ld_pending     = pend;
  assign hz.ld_outstanding = cnt;
  assign hz.fence_busy     = (state == FENCE_WAIT);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Random-stimulus bench for hazard_ctrl against a model
// built on a list of in-flight loads.
module tb_hazard_ctrl;

  localparam int ML = 4;
  localparam int NB = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hz();

  hazard_ctrl #(
    .MAX_LOADS(ML),
    .REDIRECT_BUBBLES(NB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz(hz.slave)
  );

  int ntot  = 0;
  int npass = 0;

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t",
                  tag, got, exp, $time);
  endtask

  int q[$];
  bit fwait;
  int bleft;
  int di;

  logic        e_stall, e_fire, e_flush;
  logic [31:0] e_pend;
  bit          release_ok;

  function automatic logic [31:0] mpend();
    logic [31:0] p = 32'd0;
    foreach (q[i]) if (q[i] != 0) p[q[i]] = 1'b1;
    return p;
  endfunction

  task automatic expect_now();
    bit raw, waw, full, busy;
    e_pend = mpend();
    raw = (hz.id_rs1_r_ena && hz.id_rs1_r_addr != 0
           && e_pend[hz.id_rs1_r_addr])
       || (hz.id_rs2_r_ena && hz.id_rs2_r_addr != 0
           && e_pend[hz.id_rs2_r_addr]);
    waw = hz.id_rd_w_ena && hz.id_rd_w_addr != 0
          && e_pend[hz.id_rd_w_addr];
    full = hz.id_mem_to_reg && q.size() == ML;
    busy = q.size() != 0 || hz.mem_busy;
    release_ok = 1'b0;
    e_flush = hz.ex_redirect || bleft > 0;
    if (bleft > 0 || hz.ex_redirect) e_stall = 1'b0;
    else if (fwait) begin
      e_stall = busy;
      release_ok = !busy;
    end else if (hz.id_valid && hz.id_fence && busy)
      e_stall = 1'b1;
    else e_stall = hz.id_valid && (raw || waw || full);
    e_fire = hz.id_valid && !e_stall && !e_flush;
  endtask

  task automatic check_all();
    chk("stall", 32'(hz.id_stall), 32'(e_stall));
    chk("fire", 32'(hz.id_fire), 32'(e_fire));
    chk("flush_if", 32'(hz.flush_if), 32'(e_flush));
    chk("flush_id", 32'(hz.flush_id), 32'(e_flush));
    chk("pending", hz.ld_pending, e_pend);
    chk("outst", 32'(hz.ld_outstanding), q.size());
    chk("fence_busy", 32'(hz.fence_busy), 32'(fwait));
  endtask

  task automatic update_model();
    if (hz.ex_redirect) begin
      fwait = 1'b0;
      bleft = NB;
    end else if (bleft > 0) bleft--;
    else if (fwait) begin
      if (release_ok) fwait = 1'b0;
    end else if (hz.id_valid && hz.id_fence
                 && (q.size() != 0 || hz.mem_busy))
      fwait = 1'b1;
    if (hz.ld_done && di >= 0) q.delete(di);
    if (e_fire && hz.id_mem_to_reg)
      q.push_back(int'(hz.id_rd_w_addr));
  endtask

  task automatic drive_rand(int done_pct);
    bit ld;
    ld = $urandom_range(99) < 40;
    hz.id_valid      = $urandom_range(99) < 85;
    hz.id_rs1_r_ena  = $urandom_range(1);
    hz.id_rs1_r_addr = 5'($urandom_range(7));
    hz.id_rs2_r_ena  = $urandom_range(1);
    hz.id_rs2_r_addr = 5'($urandom_range(7));
    hz.id_rd_w_ena   = ld | $urandom_range(1);
    hz.id_rd_w_addr  = 5'($urandom_range(7));
    hz.id_mem_to_reg = ld;
    hz.id_fence      = !ld && $urandom_range(99) < 8;
    hz.ex_redirect   = $urandom_range(99) < 4;
    hz.mem_busy      = $urandom_range(99) < 30;
    di = -1;
    hz.ld_done = 1'b0;
    hz.ld_done_addr = 5'($urandom_range(31));
    if (q.size() > 0) begin
      if ($urandom_range(99) < done_pct) begin
        di = $urandom_range(q.size() - 1);
        hz.ld_done = 1'b1;
        hz.ld_done_addr = 5'(q[di]);
      end
    end else begin
      hz.ld_done = $urandom_range(99) < 5;
    end
  endtask

  task automatic drive_x0_load();
    hz.id_valid      = 1'b1;
    hz.id_rs1_r_ena  = 1'b0;
    hz.id_rs2_r_ena  = 1'b0;
    hz.id_rd_w_ena   = 1'b1;
    hz.id_rd_w_addr  = 5'd0;
    hz.id_mem_to_reg = 1'b1;
    hz.id_fence      = 1'b0;
    hz.ex_redirect   = 1'b0;
    hz.ld_done       = 1'b0;
    hz.mem_busy      = 1'b0;
    di = -1;
  endtask

  initial begin
    int pct[3];
    bit x0;
    pct[0] = 10; pct[1] = 35; pct[2] = 60;
    x0 = 1'b0;
    fwait = 1'b0;
    bleft = 0;
    drive_rand(0);
    hz.id_valid = 1'b1;
    hz.ex_redirect = 1'b0;
    hz.ld_done = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    expect_now();
    check_all();
    chk("rst_fire_eq_valid", 32'(hz.id_fire), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        rst = 1'b1;
        if (x0) begin
          drive_x0_load();
          x0 = 1'b0;
        end else begin
          drive_rand(pct[ph]);
          if (n == 199) hz.ex_redirect = 1'b1;
        end
        #2;
        expect_now();
        check_all();
        @(posedge clk);
        update_model();
        if (n == 199) begin
          #2;
          rst = 1'b0;
          hz.ex_redirect = 1'b0;
          #1;
          q.delete();
          fwait = 1'b0;
          bleft = 0;
          chk("ar_pending", hz.ld_pending, 32'd0);
          chk("ar_outst", 32'(hz.ld_outstanding), 32'd0);
          chk("ar_flush", 32'(hz.flush_id), 32'd0);
          chk("ar_fbusy", 32'(hz.fence_busy), 32'd0);
          chk("ar_stall", 32'(hz.id_stall), 32'd0);
          chk("ar_fire", 32'(hz.id_fire),
              32'(hz.id_valid));
          x0 = 1'b1;
        end
      end
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline interlock and sequencing controller for the decode stage of the RV64 in-order core.
- Keeps a load scoreboard and an outstanding-load counter, and detects load-use and WAW hazards against the operands that id_stage decodes.
- Sequences fence/fence.i drains and branch/jump redirect bubbles.
- Drives the ID stall/fire qualifiers and the IF/ID flush lines.

Parameters:
- MAX_LOADS, 4: maximum in-flight loads (issued, not yet written back); range 1..15.
- REDIRECT_BUBBLES, 1: extra cycles flush_if/flush_id stay high after ex_redirect; range 0..7.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock; asynchronous, active-low (rst==0 resets)
- id_valid  in  1  ID holds a valid instruction
- id_rs1_r_ena  in  1  ID reads rs1
- id_rs1_r_addr  in  5  rs1 index
- id_rs2_r_ena  in  1  ID reads rs2
- id_rs2_r_addr  in  5  rs2 index
- id_rd_w_ena  in  1  ID writes rd
- id_rd_w_addr  in  5  rd index
- id_mem_to_reg  in  1  ID instruction is a load
- id_fence  in  1  ID instruction is fence or fence.i
- ex_redirect  in  1  EX resolved a taken branch, jal or jalr
- ld_done  in  1  one load completes writeback this cycle
- ld_done_addr  in  5  rd of the completing load
- mem_busy  in  1  store or other memory op still in flight
- id_stall  out  1  hold IF/ID
- id_fire  out  1  ID instruction advances to EX this cycle
- flush_if  out  1  kill the fetched instruction
- flush_id  out  1  kill the ID instruction (bubble into EX)
- ld_pending  out  32  scoreboard; bit i set = load to xi in flight
- ld_outstanding  out  4  in-flight load count
- fence_busy  out  1  FSM in FENCE_WAIT

Behaviour:
- Reset (rst==0, async): ld_pending=0, ld_outstanding=0, FSM=RUN, bubble counter=0. Outputs are then id_stall=0, flush_if=0, flush_id=0, fence_busy=0, and id_fire=id_valid.
- Bit 0 of ld_pending is never set.
- Hazards are combinational and use registered ld_pending only; there is no same-cycle bypass of ld_done.
  - raw = (rs1_ena & rs1!=0 & pend[rs1]) | (rs2_ena & rs2!=0 & pend[rs2])
  - waw = rd_w_ena & rd!=0 & pend[rd]
  - full = id_mem_to_reg & (ld_outstanding==MAX_LOADS)
- FSM states are RUN, FENCE_WAIT and REDIRECT.
- RUN:
  - ex_redirect → flush_if=flush_id=1 this cycle. If REDIRECT_BUBBLES>0, go to REDIRECT with the counter loaded with REDIRECT_BUBBLES.
  - else id_valid & id_fence & (ld_outstanding!=0 | mem_busy) → id_stall=1, go to FENCE_WAIT.
  - else id_stall = id_valid & (raw|waw|full).
- FENCE_WAIT:
  - fence_busy=1, id_stall=1 until ld_outstanding==0 & !mem_busy.
  - In the release cycle id_stall=0 and id_fire=1; return to RUN.
  - ex_redirect takes priority: flush as in RUN, the fence is killed, go to REDIRECT (or RUN if REDIRECT_BUBBLES=0).
- REDIRECT:
  - flush_if=flush_id=1 and id_stall=0; decrement the counter each cycle; return to RUN after the cycle in which the counter is 1.
  - A new ex_redirect reloads the counter.
- id_fire = id_valid & ~id_stall & ~flush_id.
- Scoreboard update on clock edge:
  - Clear pend[ld_done_addr] if ld_done.
  - Set pend[id_rd_w_addr] if id_fire & id_mem_to_reg & rd!=0.
  - When set and clear hit the same index, set wins.
- Counter:
  - +1 on id_fire & id_mem_to_reg; loads with rd=0 count and complete with ld_done_addr=0.
  - −1 on ld_done.
  - Both in the same cycle → unchanged.
  - ld_done while the count is 0 is ignored: no underflow, scoreboard untouched.
  - The counter never exceeds MAX_LOADS; the full hazard guarantees this.
- Reset asserted mid-fence or mid-redirect returns to RUN immediately with all state cleared.

Test Plan:
- Load-use: fire ld x5; next cycle add x6,x5,x7 → id_stall=1 until the cycle after ld_done with addr 5; ld_pending[5] goes 1 then 0.
- WAW and same-cycle set/clear: ld x3 in flight, ld_done addr 3 in the same cycle a new ld x3 fires → pend[3] stays 1, ld_outstanding unchanged at 1.
- Full: MAX_LOADS=4, fire 4 loads to x1..x4 with no ld_done; a 5th load → id_stall=1, ld_outstanding=4; one ld_done → the load fires next cycle.
- Fence: 2 loads outstanding and mem_busy=1, fence in ID → fence_busy=1 and stall; fence fires exactly in the first cycle with count 0 and mem_busy=0.
- Redirect: REDIRECT_BUBBLES=2, ex_redirect pulse → flush_if and flush_id high for 3 cycles, id_fire=0 throughout; redirect during FENCE_WAIT → fence dropped, fence_busy=0.
- Async reset mid-REDIRECT with ld_pending=0x24: pull rst low between edges → all outputs and state at reset values immediately; x0 load fires → ld_pending stays 0, count becomes 1.
